// File: rtl/dmem_uart_dumper_pkg.sv
// rtl/dmem_uart_dumper_pkg.sv - shared state encodings and UART line constants for the memory dumper
package dmem_uart_dumper_pkg;

   typedef enum logic [2:0] {
      DMP_IDLE,
      DMP_READ,
      DMP_WAIT,
      DMP_START,
      DMP_DATA,
      DMP_STOP,
      DMP_DONE
   } dmp_state_t;

   localparam logic UART_IDLE_LVL = 1'b1;

endpackage

// File: rtl/dmem_uart_dumper_btn_debouncer.sv
// rtl/dmem_uart_dumper_btn_debouncer.sv - button synchroniser, debounce filter and rising-edge pulse
module btn_debouncer #(
   parameter int DEBOUNCE_CLKS = 1000
) (
   input  logic i_clk,
   input  logic i_rst_n,
   input  logic i_btn,
   output logic o_press_pulse
);

   localparam int CW = $clog2(DEBOUNCE_CLKS + 1);

   logic          sync_1;
   logic          sync_2;
   logic          stable;
   logic          stable_d;
   logic [CW-1:0] cnt;

   // stable only follows sync_2 after it has differed for DEBOUNCE_CLKS consecutive clocks
   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         sync_1   <= 1'b0;
         sync_2   <= 1'b0;
         stable   <= 1'b0;
         stable_d <= 1'b0;
         cnt      <= '0;
      end else begin
         sync_1   <= i_btn;
         sync_2   <= sync_1;
         stable_d <= stable;
         if (sync_2 == stable) begin
            cnt <= '0;
         end else if (cnt == CW'(DEBOUNCE_CLKS - 1)) begin
            stable <= sync_2;
            cnt    <= '0;
         end else begin
            cnt <= cnt + 1'b1;
         end
      end
   end

   assign o_press_pulse = stable & ~stable_d;

endmodule

// File: rtl/dmem_uart_dumper.sv
// rtl/dmem_uart_dumper.sv - reads data memory top-down on a button press and sends each byte as 8N1 UART
module dmem_uart_dumper
   import dmem_uart_dumper_pkg::*;
#(
   parameter int CLKS_PER_BIT  = 868,
   parameter int ADDR_W        = 10,
   parameter int DUMP_BYTES    = 4,
   parameter int DEBOUNCE_CLKS = 1000
) (
   input  logic              i_clk,
   input  logic              i_rst_n,
   input  logic              i_btn_dump,
   output logic              o_mem_rd_en,
   output logic [ADDR_W-1:0] o_mem_addr,
   input  logic [7:0]        i_mem_rdata,
   output logic              o_tx,
   output logic              o_busy,
   output logic              o_done
);

   localparam int BW = $clog2(CLKS_PER_BIT);

   dmp_state_t        state;
   dmp_state_t        state_nx;
   logic [ADDR_W-1:0] idx;
   logic [BW-1:0]     baud_cnt;
   logic [2:0]        bit_cnt;
   logic [7:0]        shreg;
   logic              tx_q;
   logic              tx_nx;
   logic              press;
   logic              baud_end;

   btn_debouncer #(.DEBOUNCE_CLKS(DEBOUNCE_CLKS)) u_btn (
      .i_clk         (i_clk),
      .i_rst_n       (i_rst_n),
      .i_btn         (i_btn_dump),
      .o_press_pulse (press)
   );

   assign baud_end = (baud_cnt == BW'(CLKS_PER_BIT - 1));

   always_comb begin
      state_nx = state;
      tx_nx    = UART_IDLE_LVL;
      case (state)
         DMP_IDLE:  if (press) state_nx = DMP_READ;
         DMP_READ:  state_nx = DMP_WAIT;
         DMP_WAIT:  state_nx = DMP_START;
         DMP_START: if (baud_end) state_nx = DMP_DATA;
         DMP_DATA:  if (baud_end && bit_cnt == 3'd7) state_nx = DMP_STOP;
         DMP_STOP:  if (baud_end) state_nx = (idx == '0) ? DMP_DONE : DMP_READ;
         DMP_DONE:  state_nx = DMP_IDLE;
         default:   state_nx = DMP_IDLE;
      endcase
      // tx is registered from the next state so the line changes exactly on state boundaries
      case (state_nx)
         DMP_START: tx_nx = 1'b0;
         DMP_DATA:  tx_nx = (state == DMP_DATA && baud_end) ? shreg[1] : shreg[0];
         default:   tx_nx = UART_IDLE_LVL;
      endcase
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state    <= DMP_IDLE;
         idx      <= '0;
         baud_cnt <= '0;
         bit_cnt  <= '0;
         shreg    <= '0;
         tx_q     <= UART_IDLE_LVL;
      end else begin
         state <= state_nx;
         tx_q  <= tx_nx;
         if (state == DMP_IDLE && press) begin
            idx <= ADDR_W'(DUMP_BYTES - 1);
         end else if (state == DMP_STOP && baud_end && idx != '0) begin
            idx <= idx - 1'b1;
         end
         if (state == DMP_WAIT) begin
            shreg <= i_mem_rdata;
         end else if (state == DMP_DATA && baud_end) begin
            shreg <= {1'b0, shreg[7:1]};
         end
         if (state inside {DMP_START, DMP_DATA, DMP_STOP} && !baud_end) begin
            baud_cnt <= baud_cnt + 1'b1;
         end else begin
            baud_cnt <= '0;
         end
         if (state == DMP_DATA) begin
            if (baud_end) bit_cnt <= bit_cnt + 1'b1;
         end else begin
            bit_cnt <= '0;
         end
      end
   end

   assign o_mem_rd_en = (state == DMP_READ);
   assign o_mem_addr  = o_mem_rd_en ? idx : '0;
   assign o_tx        = tx_q;
   assign o_busy      = (state != DMP_IDLE) && (state != DMP_DONE);
   assign o_done      = (state == DMP_DONE);

endmodule

// File: tb/tb_dmem_uart_dumper.sv
// tb/tb_dmem_uart_dumper.sv - scoreboard bench: expected bytes/addresses queued by stimulus, popped by monitors
module tb_dmem_uart_dumper;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       btn = 1'b0;
   logic       rd_en;
   logic [9:0] addr;
   logic [7:0] rdata = 8'h00;
   logic       tx;
   logic       busy;
   logic       done;

   logic [7:0] mem [0:1023];
   logic [7:0] exp_bytes[$];
   logic [9:0] exp_addr[$];
   logic [9:0] frame_log[$];

   int pass_cnt = 0;
   int total_cnt = 0;
   int cyc = 0;
   int frames = 0;
   int done_cnt = 0;
   int done_cyc = 0;
   int rd_cnt = 0;
   int first_start_cyc = 0;
   bit arm_start = 0;
   bit busy_seen = 0;

   dmem_uart_dumper #(
      .CLKS_PER_BIT(4), .ADDR_W(10), .DUMP_BYTES(4), .DEBOUNCE_CLKS(4)
   ) dut (
      .i_clk       (clk),
      .i_rst_n     (rst_n),
      .i_btn_dump  (btn),
      .o_mem_rd_en (rd_en),
      .o_mem_addr  (addr),
      .i_mem_rdata (rdata),
      .o_tx        (tx),
      .o_busy      (busy),
      .o_done      (done)
   );

   always #5 clk = ~clk;

   always @(posedge clk) begin
      cyc <= cyc + 1;
      if (rd_en) rdata <= mem[addr];
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total_cnt++;
      if (act === exp) pass_cnt++;
      else $display("FAIL %s: got %0h expected %0h", name, act, exp);
   endtask

   // address / done / busy monitor
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && busy) busy_seen = 1;
         if (rst_n && done) begin
            done_cnt++;
            done_cyc = cyc;
         end
         if (rst_n && rd_en) begin
            rd_cnt++;
            if (exp_addr.size() == 0) begin
               total_cnt++;
               $display("FAIL unexpected_read: got addr %0h expected no read", addr);
            end else begin
               check("mem_addr", 32'(addr), 32'(exp_addr.pop_front()));
            end
         end
      end
   end

   // UART decoder: samples mid-bit, aborts a frame if reset hits
   initial begin
      forever begin
         @(negedge clk);
         if (rst_n && tx == 1'b0) begin
            logic [9:0] bits;
            bit ab;
            bits = '0;
            ab = 0;
            if (arm_start) begin
               first_start_cyc = cyc;
               arm_start = 0;
            end
            for (int k = 1; k <= 38; k++) begin
               @(negedge clk);
               if (!rst_n) begin
                  ab = 1;
                  break;
               end
               if (k == 2) bits[0] = tx;
               else if (k >= 6 && k <= 34 && (k - 6) % 4 == 0) bits[(k - 6) / 4 + 1] = tx;
               else if (k == 38) bits[9] = tx;
            end
            if (!ab) begin
               frame_log.push_back(bits);
               frames++;
               check("frame_framing", 32'({bits[9], bits[0]}), 32'h2);
               if (exp_bytes.size() == 0) begin
                  total_cnt++;
                  $display("FAIL unexpected_frame: got %0h expected no frame", bits[8:1]);
               end else begin
                  check("frame_byte", 32'(bits[8:1]), 32'(exp_bytes.pop_front()));
               end
            end
         end
      end
   end

   task automatic press_btn(input int n);
      @(posedge clk);
      #1 btn = 1'b1;
      repeat (n) @(posedge clk);
      #1 btn = 1'b0;
   endtask

   task automatic wait_done(input int target);
      int n;
      n = 0;
      while (done_cnt < target && n < 5000) begin
         @(posedge clk);
         n++;
      end
      check("done_reached", 32'(done_cnt >= target), 32'h1);
   endtask

   task automatic push_dump(input logic [7:0] b3, input logic [7:0] b2,
                            input logic [7:0] b1, input logic [7:0] b0);
      exp_bytes.push_back(b3); exp_bytes.push_back(b2);
      exp_bytes.push_back(b1); exp_bytes.push_back(b0);
      for (int a = 3; a >= 0; a--) exp_addr.push_back(10'(a));
   endtask

   initial begin
      int base_f, base_d, base_r, n;
      for (int i = 0; i < 1024; i++) mem[i] = 8'h00;
      mem[3] = 8'hDE; mem[2] = 8'hAD; mem[1] = 8'hBE; mem[0] = 8'hEF;

      // 1. reset
      repeat (3) @(posedge clk);
      #1;
      check("rst_tx", 32'(tx), 32'h1);
      check("rst_busy", 32'(busy), 32'h0);
      check("rst_done", 32'(done), 32'h0);
      check("rst_rd_en", 32'(rd_en), 32'h0);
      check("rst_addr", 32'(addr), 32'h0);
      rst_n = 1'b1;
      repeat (5) @(posedge clk);

      // 2. full dump
      push_dump(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      base_f = frames; base_d = done_cnt; busy_seen = 0;
      arm_start = 1;
      press_btn(10);
      wait_done(base_d + 1);
      check("done_latency", 32'(done_cyc - first_start_cyc), 32'd166);
      repeat (40) @(posedge clk);
      #1;
      check("dump_busy_after", 32'(busy), 32'h0);
      check("dump_busy_seen", 32'(busy_seen), 32'h1);
      check("dump_frames", 32'(frames - base_f), 32'd4);
      check("dump_done_once", 32'(done_cnt - base_d), 32'd1);

      // 3. bit order
      mem[3] = 8'h01;
      push_dump(8'h01, 8'hAD, 8'hBE, 8'hEF);
      base_f = frames; base_d = done_cnt;
      press_btn(10);
      wait_done(base_d + 1);
      repeat (10) @(posedge clk);
      if (frame_log.size() > base_f) check("bit_order", 32'(frame_log[base_f]), 32'b10_0000_0010);
      else check("bit_order_frames", 32'(frame_log.size()), 32'(base_f + 1));
      mem[3] = 8'hDE;

      // 4. press during busy is dropped
      push_dump(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      base_f = frames; base_d = done_cnt; base_r = rd_cnt;
      press_btn(10);
      n = 0;
      while (frames < base_f + 1 && n < 2000) begin
         @(posedge clk);
         n++;
      end
      repeat (5) @(posedge clk);
      press_btn(10);
      wait_done(base_d + 1);
      repeat (300) @(posedge clk);
      #1;
      check("drop_frames", 32'(frames - base_f), 32'd4);
      check("drop_done_once", 32'(done_cnt - base_d), 32'd1);
      check("drop_reads", 32'(rd_cnt - base_r), 32'd4);
      check("drop_idle_busy", 32'(busy), 32'h0);

      // 5. bounce
      base_r = rd_cnt; busy_seen = 0;
      for (int i = 0; i < 6; i++) begin
         press_btn(1);
         repeat (2) @(posedge clk);
      end
      repeat (30) @(posedge clk);
      check("bounce_reads", 32'(rd_cnt - base_r), 32'd0);
      check("bounce_busy", 32'(busy_seen), 32'h0);

      // 6. reset mid-frame during data bit 0 of the first byte (0xDE, bit0 = 0)
      push_dump(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      press_btn(10);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (tx !== 1'b0 && n < 2000);
      repeat (5) @(negedge clk);
      check("mid_tx_low", 32'(tx), 32'h0);
      #1 rst_n = 1'b0;
      #1;
      check("mid_rst_tx", 32'(tx), 32'h1);
      check("mid_rst_busy", 32'(busy), 32'h0);
      repeat (3) @(posedge clk);
      exp_bytes.delete();
      exp_addr.delete();
      #1 rst_n = 1'b1;
      repeat (5) @(posedge clk);
      push_dump(8'hDE, 8'hAD, 8'hBE, 8'hEF);
      base_f = frames; base_d = done_cnt;
      press_btn(10);
      wait_done(base_d + 1);
      repeat (20) @(posedge clk);
      check("restart_frames", 32'(frames - base_f), 32'd4);
      check("exp_bytes_drained", 32'(exp_bytes.size()), 32'd0);
      check("exp_addr_drained", 32'(exp_addr.size()), 32'd0);

      $display("%0d/%0d checks passed", pass_cnt, total_cnt);
      $finish;
   end

endmodule
